// File: rtl/reaction_score_keeper.sv
// -----------------------------------------------------------------------------
// reaction_score_keeper
//
// Reader side of the reaction-game timing core. It accepts measured reaction
// times (packed BCD) over a valid/ready handshake and keeps the best (lowest)
// score. It also sequences what the seven-segment path shows: the player's
// score, then the high score, then idle. While a fresh record is on display,
// it drives an alternating LED celebration pattern.
//
// Ports
//   MAX10_CLK1_50  in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   score_valid    in   1   writer offers a score, held until accepted
//   score_bcd      in   16  {s, 0.1s, 0.01s, 0.001s} packed BCD
//   score_ready    out  1   reader can accept (transfer on valid & ready)
//   clear_hi       in   1   one-cycle pulse: forget the high score
//   disp_bcd       out  16  value routed to the BCD decoder / HEX path
//   disp_blank     out  1   1 = HEX digits blanked
//   hi_bcd         out  16  current high score (NO_SCORE when none held)
//   hi_valid       out  1   a high score is held
//   new_record     out  1   the score on display set a record
//   bad_bcd        out  1   one-cycle pulse: accepted score had a digit > 9
//   led_pattern    out  10  LED drive
// -----------------------------------------------------------------------------
module reaction_score_keeper #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned SHOW_MS  = 2000,
    parameter int unsigned BLINK_MS = 250,
    parameter logic [15:0] NO_SCORE = 16'h9999
) (
    input  logic        MAX10_CLK1_50,
    input  logic        rst_n,
    input  logic        score_valid,
    input  logic [15:0] score_bcd,
    output logic        score_ready,
    input  logic        clear_hi,
    output logic [15:0] disp_bcd,
    output logic        disp_blank,
    output logic [15:0] hi_bcd,
    output logic        hi_valid,
    output logic        new_record,
    output logic        bad_bcd,
    output logic [9:0]  led_pattern
);

    localparam int unsigned MS_CYC = CLK_HZ / 1000;
    localparam int PRE_W = (MS_CYC   > 1) ? $clog2(MS_CYC)   : 1;
    localparam int MS_W  = (SHOW_MS  > 1) ? $clog2(SHOW_MS)  : 1;
    localparam int BL_W  = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [9:0] LED_A = 10'b1010101010;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHOW_SCORE,
        SHOW_HI
    } state_t;

    state_t             state;
    logic [15:0]        score_q;
    logic [PRE_W-1:0]   pre_cnt;
    logic [MS_W-1:0]    ms_cnt;
    logic [BL_W-1:0]    blink_cnt;

    logic               digits_bad;
    logic               is_record;
    logic [15:0]        hi_clr_bcd;
    logic               hi_clr_valid;
    logic [15:0]        hi_bcd_nxt;
    logic               hi_valid_nxt;
    logic               ms_tick;
    logic               phase_done;
    logic               blink_tick;

    // The clear pulse is folded in before the record compare, so a score
    // captured in the same cycle as a clear always becomes the new record.
    // The display paths use the next-cycle high score so a clear shows on the
    // very next cycle rather than one cycle late.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        digits_bad   = (score_q[15:12] > 4'd9) || (score_q[11:8] > 4'd9) ||
                       (score_q[7:4]   > 4'd9) || (score_q[3:0]  > 4'd9);
        hi_clr_bcd   = clear_hi ? NO_SCORE : hi_bcd;
        hi_clr_valid = clear_hi ? 1'b0     : hi_valid;
        // Packed BCD orders the same as plain unsigned binary.
        is_record    = !hi_clr_valid || (score_q < hi_clr_bcd);
        hi_bcd_nxt   = hi_clr_bcd;
        hi_valid_nxt = hi_clr_valid;
        if (state == CAPTURE && !digits_bad && is_record) begin
            hi_bcd_nxt   = score_q;
            hi_valid_nxt = 1'b1;
        end
        ms_tick    = (pre_cnt == PRE_W'(MS_CYC - 1));
        phase_done = ms_tick && (ms_cnt == MS_W'(SHOW_MS - 1));
        blink_tick = ms_tick && (blink_cnt == BL_W'(BLINK_MS - 1));
    end

    // NOTE: the reset branch is asynchronous (in the sensitivity list) and
    // every register here, the latched score included, returns to a known
    // value so a mid-phase reset forgets everything at once.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            score_q     <= '0;
            pre_cnt     <= '0;
            ms_cnt      <= '0;
            blink_cnt   <= '0;
            score_ready <= 1'b0;
            disp_bcd    <= '0;
            disp_blank  <= 1'b1;
            hi_bcd      <= NO_SCORE;
            hi_valid    <= 1'b0;
            new_record  <= 1'b0;
            bad_bcd     <= 1'b0;
            led_pattern <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later statements
            // in this block override earlier defaults without ordering races.
            hi_bcd   <= hi_bcd_nxt;
            hi_valid <= hi_valid_nxt;
            bad_bcd  <= 1'b0;

            // Free-running timebase; restarted on entry to each SHOW phase.
            pre_cnt <= ms_tick ? '0 : pre_cnt + 1'b1;
            if (ms_tick) begin
                ms_cnt    <= ms_cnt + 1'b1;
                blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    disp_bcd    <= hi_bcd_nxt;
                    disp_blank  <= !hi_valid_nxt;
                    led_pattern <= '0;
                    new_record  <= 1'b0;
                    if (score_valid && score_ready) begin
                        score_q     <= score_bcd;
                        score_ready <= 1'b0;
                        state       <= CAPTURE;
                    end else begin
                        score_ready <= 1'b1;
                    end
                end

                CAPTURE: begin
                    if (digits_bad) begin
                        bad_bcd     <= 1'b1;
                        score_ready <= 1'b1;
                        disp_bcd    <= hi_bcd_nxt;
                        disp_blank  <= !hi_valid_nxt;
                        state       <= IDLE;
                    end else begin
                        disp_bcd    <= score_q;
                        disp_blank  <= 1'b0;
                        new_record  <= is_record;
                        led_pattern <= is_record ? LED_A : '0;
                        pre_cnt     <= '0;
                        ms_cnt      <= '0;
                        blink_cnt   <= '0;
                        state       <= SHOW_SCORE;
                    end
                end

                SHOW_SCORE: begin
                    // The two patterns are complements, so inversion alternates them.
                    if (blink_tick && new_record) begin
                        led_pattern <= ~led_pattern;
                    end
                    if (phase_done) begin
                        disp_bcd    <= hi_bcd_nxt;
                        disp_blank  <= !hi_valid_nxt;
                        led_pattern <= '0;
                        new_record  <= 1'b0;
                        pre_cnt     <= '0;
                        ms_cnt      <= '0;
                        blink_cnt   <= '0;
                        state       <= SHOW_HI;
                    end
                end

                SHOW_HI: begin
                    disp_bcd   <= hi_bcd_nxt;
                    disp_blank <= !hi_valid_nxt;
                    if (phase_done) begin
                        score_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_score_keeper.sv
// -----------------------------------------------------------------------------
// Bench for reaction_score_keeper with small timing parameters
// (4 cycles per ms, 12-cycle display phases, 4-cycle LED toggle).
// Each offered score pushes its expected outcome onto a queue; the outcome is
// popped and compared when the block starts displaying that transaction.
// -----------------------------------------------------------------------------
module tb_reaction_score_keeper;

    localparam int unsigned CLK_HZ   = 4000;
    localparam int unsigned SHOW_MS  = 3;
    localparam int unsigned BLINK_MS = 1;
    localparam logic [15:0] NO_SCORE = 16'h9999;
    localparam int          PHASE    = 12;
    localparam int          BLINK    = 4;
    localparam logic [9:0]  LED_A    = 10'b1010101010;
    localparam logic [9:0]  LED_B    = 10'b0101010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        score_valid = 1'b0;
    logic [15:0] score_bcd = '0;
    logic        score_ready;
    logic        clear_hi = 1'b0;
    logic [15:0] disp_bcd;
    logic        disp_blank;
    logic [15:0] hi_bcd;
    logic        hi_valid;
    logic        new_record;
    logic        bad_bcd;
    logic [9:0]  led_pattern;

    reaction_score_keeper #(
        .CLK_HZ   (CLK_HZ),
        .SHOW_MS  (SHOW_MS),
        .BLINK_MS (BLINK_MS),
        .NO_SCORE (NO_SCORE)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .score_valid   (score_valid),
        .score_bcd     (score_bcd),
        .score_ready   (score_ready),
        .clear_hi      (clear_hi),
        .disp_bcd      (disp_bcd),
        .disp_blank    (disp_blank),
        .hi_bcd        (hi_bcd),
        .hi_valid      (hi_valid),
        .new_record    (new_record),
        .bad_bcd       (bad_bcd),
        .led_pattern   (led_pattern)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic        bad;
        logic        rec;
        logic [15:0] hi;
        logic        hv;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_hi = NO_SCORE;
    logic        m_v  = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, score_ready, 1'b0);
        check({tag, "_disp"},  disp_bcd,    16'h0000);
        check({tag, "_blank"}, disp_blank,  1'b1);
        check({tag, "_hi"},    hi_bcd,      NO_SCORE);
        check({tag, "_hiv"},   hi_valid,    1'b0);
        check({tag, "_rec"},   new_record,  1'b0);
        check({tag, "_bad"},   bad_bcd,     1'b0);
        check({tag, "_led"},   led_pattern, 10'd0);
    endtask

    // Model the outcome, push it, and start offering the score.
    task automatic present(input logic [15:0] score, input logic clr);
        exp_t        e;
        logic [15:0] h;
        logic        v;
        h = clr ? NO_SCORE : m_hi;
        v = clr ? 1'b0 : m_v;
        e.bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (score[k*4 +: 4] >= 4'd10) e.bad = 1'b1;
        end
        e.rec = !e.bad && (!v || score < h);
        if (e.rec) begin
            h = score;
            v = 1'b1;
        end
        m_hi    = h;
        m_v     = v;
        e.score = score;
        e.hi    = h;
        e.hv    = v;
        exp_q.push_back(e);
        score_bcd   = score;
        score_valid = 1'b1;
    endtask

    // Wait (bounded) for the transfer; leaves us in the CAPTURE cycle.
    task automatic accept(input logic clr);
        int k;
        k = 0;
        while (!score_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait_ready", score_ready, 1'b1);
        @(negedge clk);
        check("capture_ready_low", score_ready, 1'b0);
        score_valid = 1'b0;
        clear_hi    = clr;
    endtask

    // Pop the expected outcome and follow the DUT through both display phases.
    task automatic monitor(input logic hold_en, input logic [15:0] hold_score, input int clr_at);
        exp_t        e;
        logic [15:0] e_hi;
        logic        e_v;
        logic [9:0]  e_led;
        @(negedge clk);
        clear_hi = 1'b0;
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 1'b0, 1'b1);
            return;
        end
        e    = exp_q.pop_front();
        e_hi = e.hi;
        e_v  = e.hv;
        if (e.bad) begin
            check("bad_pulse",    bad_bcd,     1'b1);
            check("bad_ready",    score_ready, 1'b1);
            check("bad_hi",       hi_bcd,      e.hi);
            check("bad_hiv",      hi_valid,    e.hv);
            check("bad_disp",     disp_bcd,    e.hi);
            check("bad_blank",    disp_blank,  !e.hv);
            check("bad_rec",      new_record,  1'b0);
            @(negedge clk);
            check("bad_pulse_end", bad_bcd,    1'b0);
            check("bad_idle_ready", score_ready, 1'b1);
            return;
        end
        check("score_hi",  hi_bcd,   e.hi);
        check("score_hiv", hi_valid, e.hv);
        check("score_bad", bad_bcd,  1'b0);
        for (int i = 0; i < PHASE; i++) begin
            if (i > 0) @(negedge clk);
            e_led = !e.rec ? 10'd0 : (((i / BLINK) % 2) == 0) ? LED_A : LED_B;
            check("score_disp",  disp_bcd,    e.score);
            check("score_blank", disp_blank,  1'b0);
            check("score_rec",   new_record,  e.rec);
            check("score_led",   led_pattern, e_led);
            check("score_ready", score_ready, 1'b0);
            if (hold_en && i == 3) present(hold_score, 1'b0);
        end
        for (int j = 0; j < PHASE; j++) begin
            @(negedge clk);
            clear_hi = 1'b0;
            if (clr_at >= 0 && j == clr_at + 1) begin
                e_hi = NO_SCORE;
                e_v  = 1'b0;
                m_hi = NO_SCORE;
                m_v  = 1'b0;
                check("hi_after_clear",  hi_bcd,   NO_SCORE);
                check("hiv_after_clear", hi_valid, 1'b0);
            end
            check("hi_disp",  disp_bcd,    e_hi);
            check("hi_blank", disp_blank,  !e_v);
            check("hi_led",   led_pattern, 10'd0);
            check("hi_rec",   new_record,  1'b0);
            check("hi_ready", score_ready, 1'b0);
            if (j == clr_at) clear_hi = 1'b1;
        end
        @(negedge clk);
        check("idle_ready", score_ready, 1'b1);
        check("idle_disp",  disp_bcd,    e_hi);
        check("idle_blank", disp_blank,  !e_v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #20;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", score_ready, 1'b1);
        check("idle_disp_no_score", disp_bcd, NO_SCORE);
        check("idle_blank_no_score", disp_blank, 1'b1);

        // First score is a record; equal score is not; lower score is.
        present(16'h0412, 1'b0); accept(1'b0); monitor(1'b0, '0, -1);
        present(16'h0412, 1'b0); accept(1'b0); monitor(1'b0, '0, -1);
        present(16'h0398, 1'b0); accept(1'b0); monitor(1'b0, '0, -1);

        // Non-BCD digit: flagged, high score untouched.
        present(16'h0A12, 1'b0); accept(1'b0); monitor(1'b0, '0, -1);

        // Second score held during the first's display: one transfer, in IDLE.
        present(16'h0500, 1'b0); accept(1'b0); monitor(1'b1, 16'h0300, -1);
        accept(1'b0); monitor(1'b0, '0, -1);
        @(negedge clk);
        check("single_transfer_ready", score_ready, 1'b1);
        check("single_transfer_hi",    hi_bcd,      16'h0300);

        // Clear in the CAPTURE cycle: a slower score becomes the record.
        present(16'h0999, 1'b1); accept(1'b1); monitor(1'b0, '0, -1);

        // Reset pulse in the middle of SHOW_SCORE.
        present(16'h0250, 1'b0); accept(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        void'(exp_q.pop_front());
        m_hi = NO_SCORE;
        m_v  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", score_ready, 1'b1);
        check("post_reset_hiv",   hi_valid,    1'b0);
        check("post_reset_blank", disp_blank,  1'b1);
        check("post_reset_led",   led_pattern, 10'd0);

        // Fresh record after reset, then a clear during SHOW_HI.
        present(16'h0700, 1'b0); accept(1'b0); monitor(1'b0, '0, 5);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
